control_unit_mips: RTL
======================

# control_unit_mips

Multicycle MIPS main control FSM. Decodes the instruction opcode and sequences the datapath through fetch, decode, memory, execute and write-back states. Directly upstream of the branch-decision stage: its `Beq`/`Bne` outputs, qualified by the ALU zero flag there, become the conditional `Branch` term. `PCWrite` from this block is ORed with `Branch` at the PC enable.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock, all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `Opcode`  in  6  instruction bits [31:26] from the instruction register
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `MemWrite`  out  1  data memory write strobe
- `IRWrite`  out  1  instruction register load
- `RegDst`  out  2  write register select: 00 = rt, 01 = rd, 10 = $31
- `MemtoReg`  out  2  write-back data select: 00 = ALUOut, 01 = MDR, 10 = PC
- `RegWrite`  out  1  register file write enable
- `ALUSrcA`  out  1  ALU A select: 0 = PC, 1 = A register
- `ALUSrcB`  out  2  ALU B select: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- `ALUOp`  out  2  00 = add, 01 = subtract, 10 = funct-decoded
- `PCSrc`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `PCWrite`  out  1  unconditional PC write
- `Beq`  out  1  branch-if-equal request to the branch stage
- `Bne`  out  1  branch-if-not-equal request to the branch stage
- `Illegal`  out  1  one-cycle pulse on an undecoded opcode
- `State`  out  4  current state encoding, for debug

## Operation
- Opcodes: R-type 0x00, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, ADDI 0x08, J 0x02, JAL 0x03.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, JAL=12.
- Outputs are Moore, decoded from the state register (plus the latched opcode in BRANCH). Every output not listed for a state is 0.
- FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01. Next state is DECODE.
- DECODE: ALUSrcB=11. Opcode is latched into an internal `Op_reg`, and the next state is chosen from it:
  - LW or SW -> MEMADR
  - R-type -> EXECUTE
  - BEQ or BNE -> BRANCH
  - ADDI -> ADDIEXEC
  - J -> JUMP
  - JAL -> JAL
  - anything else -> FETCH, with Illegal=1 during this DECODE cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10. Next is MEMREAD if `Op_reg` is LW, otherwise MEMWRITE.
- MEMREAD: IorD=1. Next state is MEMWB.
- MEMWB: MemtoReg=01, RegWrite=1. Next state is FETCH.
- MEMWRITE: IorD=1, MemWrite=1. Next state is FETCH.
- EXECUTE: ALUSrcA=1, ALUOp=10. Next state is ALUWB.
- ALUWB: RegDst=01, RegWrite=1. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Beq=(`Op_reg`==0x04), Bne=(`Op_reg`==0x05). Next state is FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10. Next state is ADDIWB.
- ADDIWB: RegWrite=1. Next state is FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next state is FETCH.
- JAL: PCSrc=10, PCWrite=1, RegDst=10, MemtoReg=10, RegWrite=1. Next state is FETCH.
- Beq and Bne are never both 1 at the same time.
- `Opcode` is ignored outside DECODE; only `Op_reg` steers later states.

## Timing
- Reset: asserting `reset` low forces state to FETCH and `Op_reg` to 0x00 immediately, without waiting for a clock edge.
  - While reset is held, outputs show FETCH values: IRWrite=1, PCWrite=1, ALUSrcB=01, all others 0, State=0.
  - The first rising edge after reset deassertion moves the FSM to DECODE.
- Reset mid-instruction aborts the instruction. No partial write-back occurs after reset deasserts.
- Cycles from FETCH to the next FETCH:
  - LW: 5
  - SW, R-type, ADDI: 4
  - BEQ, BNE, J, JAL: 3
  - illegal opcode: 2
- Illegal is combinational from state DECODE and `Opcode`, and lasts exactly one cycle.
- Unused state encodings 13–15 return to FETCH on the next edge with all outputs 0.

## Configuration
- `JAL_SUPPORT_EN` defined: opcode 0x03 goes to the JAL state as described above.
- `JAL_SUPPORT_EN` undefined:
  - The JAL state is not compiled in.
  - Opcode 0x03 is illegal: DECODE -> FETCH with Illegal=1.
  - RegDst=10 and MemtoReg=10 are never driven.
  - Port widths are unchanged.

## Test plan
- Reset low for 3 cycles, then high -> State=0 with IRWrite=1 and PCWrite=1 while low; State=1 on the first edge after release.
- Opcode=0x23 (LW) -> State sequence 0,1,2,3,4,0. MemtoReg=01 and RegWrite=1 only in state 4; IorD=1 only in state 3.
- Opcode=0x05 (BNE), then Opcode changed to 0x04 after DECODE -> in state 8, Bne=1, Beq=0, ALUOp=01, PCSrc=01; the sequence returns to 0 after 3 cycles.
- Opcode=0x3F -> Illegal=1 for exactly one cycle in state 1, then State=0, with no RegWrite/MemWrite asserted.
- Opcode=0x03 with `JAL_SUPPORT_EN` -> state 12 with RegDst=10, MemtoReg=10, RegWrite=1, PCWrite=1. Without the macro -> Illegal=1 and return to FETCH.
- Reset pulsed low during state 3 of LW -> State=0 asynchronously; no RegWrite pulse is seen after release until a new instruction reaches a write-back state.

Source files
------------

// File: rtl/control_unit_mips.sv
// control_unit_mips
//   Multicycle MIPS main control FSM. It sequences the datapath through
//   fetch, decode, memory, execute and write-back states. Control outputs are
//   registered Moore outputs: each one is computed from the next state and
//   the next latched opcode, so it always matches the State output. Illegal
//   is the exception. It is combinational from DECODE and the live Opcode.
//
// Optional feature: define JAL_SUPPORT_EN to decode opcode 0x03 (JAL) into
//   its own state. When the macro is undefined, 0x03 is treated as illegal.
//
// Ports
//   clk, reset   : rising-edge clock, asynchronous active-low reset
//   Opcode[5:0]  : IR[31:26], sampled only in DECODE
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite : datapath controls
//   Beq, Bne     : conditional branch requests sent to the branch stage
//   Illegal      : one-cycle pulse in DECODE when the opcode is undecoded
//   State[3:0]   : current state, for debug
module control_unit_mips (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       Beq,
  output logic       Bne,
  output logic       Illegal,
  output logic [3:0] State
);
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;
`ifdef JAL_SUPPORT_EN
  localparam logic [5:0] OP_JAL  = 6'h03;
`endif

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
`ifdef JAL_SUPPORT_EN
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12
`else
    S_JUMP     = 4'd11
`endif
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       beq;
    logic       bne;
  } ctl_t;

  state_t     state, state_nxt;
  logic [5:0] op_reg, op_nxt;
  ctl_t       ctl;

  // Gives the Moore control word for a state. op only affects BRANCH.
  // Unused encodings fall through to the default and output all zeros.
  function automatic ctl_t decode_ctl(input state_t st, input logic [5:0] op);
    ctl_t c;
    c = '0;
    case (st)
      S_FETCH:    begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
      S_DECODE:   c.alusrcb = 2'b11;
      S_MEMADR:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMREAD:  c.iord = 1'b1;
      S_MEMWB:    begin c.memtoreg = 2'b01; c.regwrite = 1'b1; end
      S_MEMWRITE: begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_EXECUTE:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      S_ALUWB:    begin c.regdst = 2'b01; c.regwrite = 1'b1; end
      S_BRANCH: begin
        c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01;
        c.beq = (op == OP_BEQ);
        c.bne = (op == OP_BNE);
      end
      S_ADDIEXEC: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB:   c.regwrite = 1'b1;
      S_JUMP:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
`ifdef JAL_SUPPORT_EN
      S_JAL: begin
        c.pcsrc = 2'b10; c.pcwrite = 1'b1; c.regdst = 2'b10;
        c.memtoreg = 2'b10; c.regwrite = 1'b1;
      end
`endif
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nxt = S_FETCH;
    op_nxt    = op_reg;
    Illegal   = 1'b0;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        op_nxt = Opcode;
        case (Opcode)
          OP_LW, OP_SW:   state_nxt = S_MEMADR;
          OP_R:           state_nxt = S_EXECUTE;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_ADDI:        state_nxt = S_ADDIEXEC;
          OP_J:           state_nxt = S_JUMP;
`ifdef JAL_SUPPORT_EN
          OP_JAL:         state_nxt = S_JAL;
`endif
          default: begin state_nxt = S_FETCH; Illegal = 1'b1; end
        endcase
      end
      S_MEMADR:   state_nxt = (op_reg == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nxt = S_MEMWB;
      S_EXECUTE:  state_nxt = S_ALUWB;
      S_ADDIEXEC: state_nxt = S_ADDIWB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // The reset value of ctl is the FETCH word, so the outputs show FETCH
  // as soon as reset is asserted. Any write-back in progress is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_FETCH;
      op_reg <= 6'h00;
      ctl    <= decode_ctl(S_FETCH, 6'h00);
    end else begin
      state  <= state_nxt;
      op_reg <= op_nxt;
      ctl    <= decode_ctl(state_nxt, op_nxt);
    end
  end

  assign IorD     = ctl.iord;
  assign MemWrite = ctl.memwrite;
  assign IRWrite  = ctl.irwrite;
  assign RegDst   = ctl.regdst;
  assign MemtoReg = ctl.memtoreg;
  assign RegWrite = ctl.regwrite;
  assign ALUSrcA  = ctl.alusrca;
  assign ALUSrcB  = ctl.alusrcb;
  assign ALUOp    = ctl.aluop;
  assign PCSrc    = ctl.pcsrc;
  assign PCWrite  = ctl.pcwrite;
  assign Beq      = ctl.beq;
  assign Bne      = ctl.bne;
  assign State    = state;
endmodule
